// File: rtl/dm_latency_ctrl_if.sv
// Request/response bundle between the MEM stage and dm_latency_ctrl.
// The master side issues accesses; the slave side answers them.
interface dm_latency_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  DMSel;
    logic [31:0] A;
    logic [31:0] D;
    logic        ready;
    logic        stall;
    logic        rvalid;
    logic [31:0] Q;
    logic        err;
    logic        Exam_valid;
    logic [31:0] Exam_A;
    logic [31:0] Exam_RAM_D;

    modport master (
        output req, we, DMSel, A, D,
        input  ready, stall, rvalid, Q, err,
        input  Exam_valid, Exam_A, Exam_RAM_D
    );

    modport slave (
        input  req, we, DMSel, A, D,
        output ready, stall, rvalid, Q, err,
        output Exam_valid, Exam_A, Exam_RAM_D
    );
endinterface

// File: rtl/dm_latency_ctrl.sv
// Fixed-latency data memory for the MEM stage: byte/half/word access,
// load extension, fault detection and pipeline stall generation.
module dm_latency_ctrl #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input logic              clk,
    input logic              RESET,
    dm_latency_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [32:0] SPAN = 33'd4 << ADDR_WIDTH;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [2:0]  sel_q;
    logic [31:0] a_q;
    logic [31:0] d_q;
    logic        fault_q;

    logic        rvalid_q;
    logic [31:0] q_q;
    logic        err_q;
    logic        ev_q;
    logic [31:0] ea_q;
    logic [31:0] ed_q;

    logic [31:0] mem [DEPTH];

    logic [31:0] off_in;
    logic        fault_in;
    logic [31:0] off_q;
    logic [ADDR_WIDTH-1:0] widx;
    logic [31:0] rd;
    logic [7:0]  b8;
    logic [15:0] h16;
    logic [31:0] merged;
    logic [31:0] ldv;
    logic        ready;

    assign ready = (state == IDLE);

    // Below BASE_ADDR the offset wraps high, so one compare covers both ends.
    assign off_in = bus.A - BASE_ADDR;
    assign fault_in =
        (bus.DMSel[1] && bus.A[1:0] != 2'b00) ||
        (bus.DMSel[1:0] == 2'b01 && bus.A[0]) ||
        ({1'b0, off_in} >= SPAN);

    assign off_q = a_q - BASE_ADDR;
    assign widx  = off_q[ADDR_WIDTH+1:2];
    assign rd    = mem[widx];
    assign b8    = rd[{a_q[1:0], 3'b000} +: 8];
    assign h16   = rd[{a_q[1], 4'b0000} +: 16];

    always_comb begin
        merged = rd;
        unique case (1'b1)
            sel_q[1]:
                merged = d_q;
            sel_q[1:0] == 2'b01:
                merged[{a_q[1], 4'b0000} +: 16] = d_q[15:0];
            default:
                merged[{a_q[1:0], 3'b000} +: 8] = d_q[7:0];
        endcase
    end

    always_comb begin
        ldv = rd;
        unique case (1'b1)
            sel_q[1]:
                ldv = rd;
            sel_q[1:0] == 2'b01:
                ldv = {{16{h16[15] & ~sel_q[2]}}, h16};
            default:
                ldv = {{24{b8[7] & ~sel_q[2]}}, b8};
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            a_q      <= '0;
            d_q      <= '0;
            fault_q  <= 1'b0;
            rvalid_q <= 1'b0;
            q_q      <= '0;
            err_q    <= 1'b0;
            ev_q     <= 1'b0;
            ea_q     <= '0;
            ed_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            rvalid_q <= 1'b0;
            ev_q     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        sel_q   <= bus.DMSel;
                        a_q     <= bus.A;
                        d_q     <= bus.D;
                        fault_q <= fault_in;
                        cnt     <= 4'(LATENCY - 1);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state    <= IDLE;
                        rvalid_q <= 1'b1;
                        if (fault_q) begin
                            q_q   <= '0;
                            err_q <= 1'b1;
                        end else if (we_q) begin
                            mem[widx] <= merged;
                            q_q   <= '0;
                            err_q <= 1'b0;
                            ev_q  <= 1'b1;
                            ea_q  <= {a_q[31:2], 2'b00};
                            ed_q  <= merged;
                        end else begin
                            q_q   <= ldv;
                            err_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready      = ready;
    assign bus.stall      = bus.req && !ready;
    assign bus.rvalid     = rvalid_q;
    assign bus.Q          = q_q;
    assign bus.err        = err_q;
    assign bus.Exam_valid = ev_q;
    assign bus.Exam_A     = ea_q;
    assign bus.Exam_RAM_D = ed_q;
endmodule

// File: tb/tb_dm_latency_ctrl.sv
// Scoreboard bench for dm_latency_ctrl: directed accesses push expected
// responses; a negedge monitor pops and compares on every rvalid.
module tb_dm_latency_ctrl;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic RESET;
    always #5 clk = ~clk;

    dm_latency_ctrl_if bus ();

    dm_latency_ctrl #(
        .ADDR_WIDTH(10),
        .LATENCY(LAT),
        .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk),
        .RESET(RESET),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] q;
        logic        err;
        logic        ev;
        logic [31:0] ea;
        logic [31:0] ed;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (RESET === 1'b0) begin
            if (bus.rvalid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    me = sb.pop_front();
                    chk("latency", 32'(cyc - me.cyc), 32'(LAT));
                    chk("Q", bus.Q, me.q);
                    chk("err", 32'(bus.err), 32'(me.err));
                    chk("Exam_valid", 32'(bus.Exam_valid), 32'(me.ev));
                    if (me.ev) begin
                        chk("Exam_A", bus.Exam_A, me.ea);
                        chk("Exam_RAM_D", bus.Exam_RAM_D, me.ed);
                    end
                end
            end else if (bus.Exam_valid) begin
                chk("stray_exam_valid", 32'd1, 32'd0);
            end
        end
    end

    task automatic push(logic [31:0] a, logic [31:0] q,
                        logic err, logic ev, logic [31:0] ed);
        exp_t e;
        e.q   = q;
        e.err = err;
        e.ev  = ev;
        e.ea  = {a[31:2], 2'b00};
        e.ed  = ed;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic send(logic we, logic [2:0] sel, logic [31:0] a,
                        logic [31:0] d, logic [31:0] q, logic err,
                        logic ev, logic [31:0] ed, bit do_push);
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = we;
        bus.DMSel = sel;
        bus.A     = a;
        bus.D     = d;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        if (do_push) push(a, q, err, ev, ed);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("response_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    task automatic op(logic we, logic [2:0] sel, logic [31:0] a,
                      logic [31:0] d, logic [31:0] q, logic err,
                      logic ev, logic [31:0] ed);
        send(we, sel, a, d, q, err, ev, ed, 1'b1);
        drain();
    endtask

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SBU = 3'b100;
    localparam logic [2:0] SHU = 3'b101;

    logic [2:0]  bsel [4];
    logic [31:0] ba   [4];
    logic [31:0] bq   [4];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int prev;
        bsel = '{SW, SH, SBU, SB};
        ba   = '{32'h10, 32'h12, 32'h13, 32'h10};
        bq   = '{32'h80015678, 32'hFFFF8001, 32'h00000080, 32'h00000078};

        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.DMSel = SW;
        bus.A     = 32'h40;
        bus.D     = 32'hDEADBEEF;
        RESET     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_Q", bus.Q, 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_Exam_valid", 32'(bus.Exam_valid), 32'd0);
        chk("rst_Exam_A", bus.Exam_A, 32'd0);
        chk("rst_Exam_RAM_D", bus.Exam_RAM_D, 32'd0);
        bus.req = 1'b0;
        RESET   = 1'b0;
        chk("idle_stall", 32'(bus.stall), 32'd0);

        op(1'b1, SW, 32'h10, 32'h12345678, 32'h0, 1'b0, 1'b1, 32'h12345678);
        op(1'b0, SW, 32'h10, 32'h0, 32'h12345678, 1'b0, 1'b0, 32'h0);

        op(1'b1, SB, 32'h13, 32'hAB, 32'h0, 1'b0, 1'b1, 32'hAB345678);
        op(1'b0, SB, 32'h13, 32'h0, 32'hFFFFFFAB, 1'b0, 1'b0, 32'h0);
        op(1'b0, SBU, 32'h13, 32'h0, 32'h000000AB, 1'b0, 1'b0, 32'h0);

        op(1'b1, SH, 32'h12, 32'h8001, 32'h0, 1'b0, 1'b1, 32'h80015678);
        op(1'b0, SH, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 1'b0, 32'h0);
        op(1'b0, SHU, 32'h12, 32'h0, 32'h00008001, 1'b0, 1'b0, 32'h0);
        op(1'b0, SH, 32'h10, 32'h0, 32'h00005678, 1'b0, 1'b0, 32'h0);

        op(1'b0, SW, 32'h12, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        op(1'b1, SH, 32'h11, 32'hFFFF, 32'h0, 1'b1, 1'b0, 32'h0);
        op(1'b0, SW, 32'h10, 32'h0, 32'h80015678, 1'b0, 1'b0, 32'h0);
        op(1'b0, SW, 32'h1000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);

        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = 1'b0;
        bus.DMSel = bsel[0];
        bus.A     = ba[0];
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (prev >= 0) chk("issue_interval", 32'(cyc - prev), 32'd3);
            prev = cyc;
            push(ba[i], bq[i], 1'b0, 1'b0, 32'h0);
            if (i < 3) begin
                bus.DMSel = bsel[i+1];
                bus.A     = ba[i+1];
            end
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                chk("stall", 32'(bus.stall), 32'(j < 2));
            end
        end
        bus.req = 1'b0;
        drain();

        send(1'b1, SW, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1,
             32'hFFFFFFFF, 1'b0);
        @(negedge clk);
        RESET   = 1'b1;
        bus.req = 1'b1;
        @(negedge clk);
        RESET   = 1'b0;
        bus.req = 1'b0;
        chk("midrst_ready", 32'(bus.ready), 32'd1);
        chk("midrst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("midrst_Exam_valid", 32'(bus.Exam_valid), 32'd0);
        chk("midrst_Q", bus.Q, 32'd0);
        repeat (4) @(negedge clk);
        op(1'b0, SW, 32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        op(1'b0, SW, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
